mm_requant_stage: RTL and testbench

MM_REQUANT_STAGE -- requirements
Module: mm_requant_stage

---
 rtl/mm_pkg.sv | 31 +++
 rtl/mm_requant_lane.sv | 42 ++++
 rtl/mm_requant_stage.sv | 192 +++++++++++++++++++
 tb/tb_mm_requant_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared state enum, default widths and lane saturation for the requant stage
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int DEF_LANES   = 16;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_SHIFT_W = 5;
    localparam int DEF_LEN_W   = 16;

    // Works on a 64-bit sign-extended value so one function serves every lane width.
    function automatic logic signed [63:0] sat_val(input logic signed [63:0] x,
                                                   input int unsigned      out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/mm_requant_lane.sv
// rtl/mm_requant_lane.sv - one lane of round, arithmetic shift and saturate (optional MM_REQUANT_RELU_EN clamp)
module mm_requant_lane
    import mm_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               round_en,
`ifdef MM_REQUANT_RELU_EN
    input  logic               relu_en,
`endif
    output logic [OUT_W-1:0]   res
);

    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;
    logic signed [63:0]    wide;
    logic signed [63:0]    sat;

    always_comb begin
        rnd = '0;
        if (round_en && (shift != '0)) begin
            rnd = $signed({{ACC_W{1'b0}}, 1'b1} << (shift - SHIFT_W'(1)));
        end
        // One extra bit keeps the rounding increment from wrapping at the positive limit.
        sum     = $signed({acc[ACC_W-1], acc}) + rnd;
        shifted = sum >>> shift;
        wide    = {{(63 - ACC_W){shifted[ACC_W]}}, shifted};
        sat     = sat_val(wide, OUT_W);
`ifdef MM_REQUANT_RELU_EN
        if (relu_en && sat[63]) begin
            sat = '0;
        end
`endif
        res = sat[OUT_W-1:0];
    end

endmodule

// File: rtl/mm_requant_stage.sv
// rtl/mm_requant_stage.sv - job-configured requantization stage with 2-entry output buffer (optional MM_REQUANT_RELU_EN)
module mm_requant_stage
    import mm_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     cfg_round,
    input  logic [LEN_W-1:0]         cfg_beats,
`ifdef MM_REQUANT_RELU_EN
    input  logic                     cfg_relu,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [LANES*ACC_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic                     busy,
    output logic                     err_last
);

    state_e                   state_q, state_d;
    logic [SHIFT_W-1:0]       shift_q, shift_d;
    logic                     round_q, round_d;
    logic [LEN_W-1:0]         beats_q, beats_d;
    logic [LEN_W-1:0]         beat_q, beat_d;
    logic                     err_q, err_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [LANES*OUT_W-1:0]   ent0_q, ent0_d, ent1_q, ent1_d;
    logic                     last0_q, last0_d, last1_q, last1_d;
`ifdef MM_REQUANT_RELU_EN
    logic                     relu_q, relu_d;
`endif

    logic [LANES*OUT_W-1:0]   res_data;
    logic                     push;
    logic                     pop;
    logic                     new_last;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mm_requant_lane #(
            .ACC_W   (ACC_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .acc      (in_data[i*ACC_W +: ACC_W]),
            .shift    (shift_q),
            .round_en (round_q),
`ifdef MM_REQUANT_RELU_EN
            .relu_en  (relu_q),
`endif
            .res      (res_data[i*OUT_W +: OUT_W])
        );
    end

    // A full buffer still accepts when the head drains in the same cycle.
    assign in_ready  = (state_q == ST_RUN) && ((cnt_q != 2'd2) || out_ready);
    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = ent0_q;
    assign out_last  = last0_q;
    assign err_last  = err_q;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign new_last = (beat_q == beats_q);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        round_d = round_q;
        beats_d = beats_q;
        beat_d  = beat_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        last0_d = last0_q;
        last1_d = last1_q;
`ifdef MM_REQUANT_RELU_EN
        relu_d  = relu_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    shift_d = cfg_shift;
                    round_d = cfg_round;
                    beats_d = cfg_beats;
`ifdef MM_REQUANT_RELU_EN
                    relu_d  = cfg_relu;
`endif
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (push) begin
                    if (new_last) begin
                        state_d = ST_DRAIN;
                        if (!in_last) err_d = 1'b1;
                    end else begin
                        if (in_last) err_d = 1'b1;
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 2'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d  = res_data;
                    last0_d = new_last;
                end else begin
                    ent1_d  = res_data;
                    last1_d = new_last;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d  = ent1_q;
                last0_d = last1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d  = res_data;
                    last0_d = new_last;
                end else begin
                    ent0_d  = ent1_q;
                    last0_d = last1_q;
                    ent1_d  = res_data;
                    last1_d = new_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            round_q <= 1'b0;
            beats_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 2'd0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
`ifdef MM_REQUANT_RELU_EN
            relu_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            round_q <= round_d;
            beats_q <= beats_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
`ifdef MM_REQUANT_RELU_EN
            relu_q  <= relu_d;
`endif
        end
    end

endmodule

// File: tb/tb_mm_requant_stage.sv
// tb/tb_mm_requant_stage.sv - directed self-checking bench for mm_requant_stage
module tb_mm_requant_stage;

    localparam int LANES   = 16;
    localparam int ACC_W   = 24;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 5;
    localparam int LEN_W   = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [SHIFT_W-1:0]     cfg_shift = '0;
    logic                   cfg_round = 1'b0;
    logic [LEN_W-1:0]       cfg_beats = '0;
    logic                   cfg_relu = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   in_last = 1'b0;
    logic [LANES*ACC_W-1:0] in_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic                   out_last;
    logic [LANES*OUT_W-1:0] out_data;
    logic                   busy;
    logic                   err_last;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mm_requant_stage #(
        .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_shift (cfg_shift),
        .cfg_round (cfg_round),
        .cfg_beats (cfg_beats),
`ifdef MM_REQUANT_RELU_EN
        .cfg_relu  (cfg_relu),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_data  (out_data),
        .busy      (busy),
        .err_last  (err_last)
    );

    function automatic logic [LANES*ACC_W-1:0] mk4(input int a, input int b, input int c, input int d);
        logic [LANES*ACC_W-1:0] v;
        v = '0;
        v[0*ACC_W +: ACC_W] = a[ACC_W-1:0];
        v[1*ACC_W +: ACC_W] = b[ACC_W-1:0];
        v[2*ACC_W +: ACC_W] = c[ACC_W-1:0];
        v[3*ACC_W +: ACC_W] = d[ACC_W-1:0];
        return v;
    endfunction

    function automatic int lane(input logic [LANES*OUT_W-1:0] v, input int i);
        logic signed [OUT_W-1:0] s;
        s = v[i*OUT_W +: OUT_W];
        return int'(s);
    endfunction

    task automatic do_cfg(input int sh, input bit rnd, input int bts, input bit rl);
        int t;
        t = 0;
        while (!cfg_ready && t < 100) begin @(negedge clk); #1; t++; end
        if (!cfg_ready) begin
            checks++;
            $display("FAIL cfg_wait cfg_ready=%0b expected=1", cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_shift = sh[SHIFT_W-1:0];
        cfg_round = rnd;
        cfg_beats = bts[LEN_W-1:0];
        cfg_relu  = rl;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
    endtask

    task automatic send_one(input logic [LANES*ACC_W-1:0] d, input bit l,
                            output bit ov, output logic [LANES*OUT_W-1:0] od, output bit ol);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!in_ready && t < 100) begin @(negedge clk); #1; t++; end
        if (!in_ready) begin
            checks++;
            $display("FAIL in_wait in_ready=%0b expected=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        ov = out_valid;
        od = out_data;
        ol = out_last;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (busy && t < 100) begin @(negedge clk); #1; t++; end
        checks++;
        if (busy !== 1'b0) $display("FAIL %s_idle busy=%0b expected=0", nm, busy);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%0b exp=0", out_valid); else passes++;
        checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last got=%0b exp=0", out_last); else passes++;
        checks++; if (out_data !== '0) $display("FAIL rst_out_data got=%0h exp=0", out_data); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%0b exp=0", in_ready); else passes++;
        checks++; if (cfg_ready !== 1'b1) $display("FAIL rst_cfg_ready got=%0b exp=1", cfg_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", busy); else passes++;
        checks++; if (err_last !== 1'b0) $display("FAIL rst_err_last got=%0b exp=0", err_last); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_round_sat();
        bit ov, ol;
        logic [LANES*OUT_W-1:0] od;
        out_ready = 1'b1;
        do_cfg(4, 1'b1, 0, 1'b0);
        send_one(mk4(40, -40, 1 << 20, -(1 << 20)), 1'b1, ov, od, ol);
        checks++; if (ov !== 1'b1) $display("FAIL rs_valid got=%0b exp=1", ov); else passes++;
        checks++; if (lane(od, 0) !== 3) $display("FAIL rs_lane0 got=%0d exp=3", lane(od, 0)); else passes++;
        checks++; if (lane(od, 1) !== -2) $display("FAIL rs_lane1 got=%0d exp=-2", lane(od, 1)); else passes++;
        checks++; if (lane(od, 2) !== 127) $display("FAIL rs_lane2 got=%0d exp=127", lane(od, 2)); else passes++;
        checks++; if (lane(od, 3) !== -128) $display("FAIL rs_lane3 got=%0d exp=-128", lane(od, 3)); else passes++;
        checks++; if (lane(od, 4) !== 0) $display("FAIL rs_lane4 got=%0d exp=0", lane(od, 4)); else passes++;
        checks++; if (ol !== 1'b1) $display("FAIL rs_last got=%0b exp=1", ol); else passes++;
        checks++; if (err_last !== 1'b0) $display("FAIL rs_err got=%0b exp=0", err_last); else passes++;
        wait_idle("rs");
    endtask

    task automatic test_truncate();
        bit ov, ol;
        logic [LANES*OUT_W-1:0] od;
        do_cfg(4, 1'b0, 0, 1'b0);
        send_one(mk4(40, -40, 0, 0), 1'b1, ov, od, ol);
        checks++; if (lane(od, 0) !== 2) $display("FAIL tr_lane0 got=%0d exp=2", lane(od, 0)); else passes++;
        checks++; if (lane(od, 1) !== -3) $display("FAIL tr_lane1 got=%0d exp=-3", lane(od, 1)); else passes++;
        wait_idle("tr");
        do_cfg(0, 1'b1, 0, 1'b0);
        send_one(mk4(100, 200, -200, -5), 1'b1, ov, od, ol);
        checks++; if (lane(od, 0) !== 100) $display("FAIL pt_lane0 got=%0d exp=100", lane(od, 0)); else passes++;
        checks++; if (lane(od, 1) !== 127) $display("FAIL pt_lane1 got=%0d exp=127", lane(od, 1)); else passes++;
        checks++; if (lane(od, 2) !== -128) $display("FAIL pt_lane2 got=%0d exp=-128", lane(od, 2)); else passes++;
        checks++; if (lane(od, 3) !== -5) $display("FAIL pt_lane3 got=%0d exp=-5", lane(od, 3)); else passes++;
        wait_idle("pt");
    endtask

    task automatic test_relu();
        bit ov, ol;
        logic [LANES*OUT_W-1:0] od;
        int exp0;
`ifdef MM_REQUANT_RELU_EN
        exp0 = 0;
`else
        exp0 = -2;
`endif
        do_cfg(4, 1'b1, 0, 1'b1);
        send_one(mk4(-40, 40, 0, 0), 1'b1, ov, od, ol);
        checks++; if (lane(od, 0) !== exp0) $display("FAIL relu_lane0 got=%0d exp=%0d", lane(od, 0), exp0); else passes++;
        checks++; if (lane(od, 1) !== 3) $display("FAIL relu_lane1 got=%0d exp=3", lane(od, 1)); else passes++;
        wait_idle("relu");
    endtask

    task automatic test_backpressure();
        int sent, got, pend, cyc;
        bit held, saw_full, acc, pop;
        logic [LANES*OUT_W-1:0] hd;
        logic hl;
        sent = 0; got = 0; pend = 0; cyc = 0;
        held = 1'b0; saw_full = 1'b0;
        hd = '0; hl = 1'b0;
        do_cfg(4, 1'b0, 7, 1'b0);
        while (got < 8 && cyc < 200) begin
            out_ready = (cyc % 2 == 0);
            in_valid  = (sent < 8);
            in_data   = mk4(sent * 16, 0, 0, 0);
            in_last   = (sent == 7);
            #1;
            if (held && out_valid) begin
                checks++; if (out_data !== hd) $display("FAIL bp_hold_data got=%0h exp=%0h", out_data, hd); else passes++;
                checks++; if (out_last !== hl) $display("FAIL bp_hold_last got=%0b exp=%0b", out_last, hl); else passes++;
            end
            held = 1'b0;
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pend == 2 && !out_ready) begin
                saw_full = 1'b1;
                checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); else passes++;
            end
            if (pop) begin
                checks++; if (lane(out_data, 0) !== got) $display("FAIL bp_data got=%0d exp=%0d", lane(out_data, 0), got); else passes++;
                checks++; if (out_last !== (got == 7)) $display("FAIL bp_last beat=%0d got=%0b exp=%0b", got, out_last, got == 7); else passes++;
                got++;
            end else if (out_valid) begin
                held = 1'b1;
                hd = out_data;
                hl = out_last;
            end
            pend = pend + int'(acc) - int'(pop);
            sent = sent + int'(acc);
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (got !== 8) $display("FAIL bp_count got=%0d exp=8", got); else passes++;
        checks++; if (saw_full !== 1'b1) $display("FAIL bp_saw_full got=%0b exp=1", saw_full); else passes++;
        checks++; if (err_last !== 1'b0) $display("FAIL bp_err got=%0b exp=0", err_last); else passes++;
        wait_idle("bp");
    endtask

    task automatic test_last_mismatch();
        bit ov, ol;
        logic [LANES*OUT_W-1:0] od;
        out_ready = 1'b1;
        do_cfg(4, 1'b0, 3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            send_one(mk4(k * 16, 0, 0, 0), (k == 1), ov, od, ol);
            checks++; if (ov !== 1'b1) $display("FAIL lm_valid beat=%0d got=%0b exp=1", k, ov); else passes++;
            checks++; if (lane(od, 0) !== k) $display("FAIL lm_data got=%0d exp=%0d", lane(od, 0), k); else passes++;
            checks++; if (ol !== (k == 3)) $display("FAIL lm_last beat=%0d got=%0b exp=%0b", k, ol, k == 3); else passes++;
            checks++; if (err_last !== (k >= 1)) $display("FAIL lm_err beat=%0d got=%0b exp=%0b", k, err_last, k >= 1); else passes++;
        end
        wait_idle("lm");
        checks++; if (err_last !== 1'b1) $display("FAIL lm_err_sticky got=%0b exp=1", err_last); else passes++;
    endtask

    task automatic test_reset_mid_job();
        bit ov, ol;
        logic [LANES*OUT_W-1:0] od;
        out_ready = 1'b0;
        do_cfg(4, 1'b0, 7, 1'b0);
        send_one(mk4(16, 0, 0, 0), 1'b0, ov, od, ol);
        send_one(mk4(32, 0, 0, 0), 1'b0, ov, od, ol);
        checks++; if (out_valid !== 1'b1) $display("FAIL mj_pending got=%0b exp=1", out_valid); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL mj_out_valid got=%0b exp=0", out_valid); else passes++;
        checks++; if (cfg_ready !== 1'b1) $display("FAIL mj_cfg_ready got=%0b exp=1", cfg_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mj_busy got=%0b exp=0", busy); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL mj_in_ready got=%0b exp=0", in_ready); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        do_cfg(4, 1'b1, 0, 1'b0);
        checks++; if (err_last !== 1'b0) $display("FAIL mj_err_clear got=%0b exp=0", err_last); else passes++;
        send_one(mk4(40, -40, 0, 0), 1'b1, ov, od, ol);
        checks++; if (ov !== 1'b1) $display("FAIL mj_valid got=%0b exp=1", ov); else passes++;
        checks++; if (lane(od, 0) !== 3) $display("FAIL mj_lane0 got=%0d exp=3", lane(od, 0)); else passes++;
        checks++; if (lane(od, 1) !== -2) $display("FAIL mj_lane1 got=%0d exp=-2", lane(od, 1)); else passes++;
        checks++; if (ol !== 1'b1) $display("FAIL mj_last got=%0b exp=1", ol); else passes++;
        checks++; if (err_last !== 1'b0) $display("FAIL mj_err got=%0b exp=0", err_last); else passes++;
        wait_idle("mj");
    endtask

    initial begin
        test_reset();
        test_round_sat();
        test_truncate();
        test_relu();
        test_backpressure();
        test_last_mismatch();
        test_reset_mid_job();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
